// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one memory port between instruction fetch (IF) and data access (DM).
// Only one memory transaction is outstanding at a time. Data requests have
// priority, but a DM grant is never followed by another DM grant while a fetch
// is waiting. Memory latency is variable; completion is signalled by mem_ack.
//
// Optional feature: define MEMARB_TIMEOUT_EN to abort a transaction after
// TIMEOUT cycles in BUSY without mem_ack. The aborted ready pulse carries
// rdata=0 and mem_err=1. Without the macro, mem_err is tied low and no counter
// exists.
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   if_req/if_addr               fetch request (level, held until if_ready)
//   if_rdata/if_ready            fetched word and one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request (level, held until dm_ready)
//   dm_rdata/dm_ready            load data and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ack
//   mem_rdata/mem_ack            memory read data and one-cycle completion
//   stall_if/stall_mem           pipeline stalls (combinational)
//   mem_err                      one-cycle timeout pulse, coincident with ready
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t nextState;

    // Owner of the most recent grant; also identifies the owner of the
    // transaction currently in BUSY/DONE, since it is recorded at grant time.
    logic lastGrantDm;

    logic pickDm;
    logic pickIf;
    logic timedOut;
    logic finish;

    logic              memReqNext;
    logic              memWeNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [DATA_W-1:0] memWdataNext;
    logic              ifReadyNext;
    logic              dmReadyNext;
    logic [DATA_W-1:0] ifRdataNext;
    logic [DATA_W-1:0] dmRdataNext;
    logic              lastGrantDmNext;

    // DM wins unless both are waiting and DM had the previous grant.
    assign pickDm = dm_req && (!if_req || !lastGrantDm);
    assign pickIf = if_req && !pickDm;

    // An ack in the same cycle as the timeout wins (timedOut requires !mem_ack).
    assign finish = mem_ack || timedOut;

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:    if (pickDm || pickIf) nextState = BUSY;
            BUSY:    if (finish)           nextState = DONE;
            DONE:                          nextState = IDLE;
            default:                       nextState = IDLE;
        endcase
    end

    always_comb begin
        memReqNext      = mem_req;
        memWeNext       = mem_we;
        memAddrNext     = mem_addr;
        memWdataNext    = mem_wdata;
        ifRdataNext     = if_rdata;
        dmRdataNext     = dm_rdata;
        lastGrantDmNext = lastGrantDm;
        ifReadyNext     = 1'b0;
        dmReadyNext     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pickDm || pickIf) begin
                    memReqNext      = 1'b1;
                    memWeNext       = pickDm ? dm_we : 1'b0;
                    memAddrNext     = pickDm ? dm_addr : if_addr;
                    memWdataNext    = pickDm ? dm_wdata : '0;
                    lastGrantDmNext = pickDm;
                end
            end
            BUSY: begin
                if (finish) begin
                    memReqNext = 1'b0;
                    // Stores and aborted transactions return zero data.
                    if (lastGrantDm) begin
                        dmReadyNext = 1'b1;
                        dmRdataNext = (mem_ack && !mem_we) ? mem_rdata : '0;
                    end else begin
                        ifReadyNext = 1'b1;
                        ifRdataNext = mem_ack ? mem_rdata : '0;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_ready    <= 1'b0;
            dm_ready    <= 1'b0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            lastGrantDm <= 1'b0;
        end else begin
            mem_req     <= memReqNext;
            mem_we      <= memWeNext;
            mem_addr    <= memAddrNext;
            mem_wdata   <= memWdataNext;
            if_ready    <= ifReadyNext;
            dm_ready    <= dmReadyNext;
            if_rdata    <= ifRdataNext;
            dm_rdata    <= dmRdataNext;
            lastGrantDm <= lastGrantDmNext;
        end
    end

`ifdef MEMARB_TIMEOUT_EN
    logic [3:0] toCnt;
    logic       errQ;

    // toCnt holds the number of ack-less BUSY cycles already elapsed, so the
    // TIMEOUT-th ack-less BUSY cycle is the one seeing TIMEOUT-1.
    assign timedOut = (state == BUSY) && !mem_ack && (toCnt == 4'(TIMEOUT - 1));

    // Every BUSY entry comes from IDLE, so clearing in IDLE clears on entry.
    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            toCnt <= '0;
        end else if (state == BUSY && !mem_ack) begin
            toCnt <= toCnt + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            errQ <= 1'b0;
        end else begin
            errQ <= timedOut;
        end
    end

    assign mem_err = errQ;
`else
    assign timedOut = 1'b0;
    assign mem_err  = 1'b0;
`endif

endmodule
